// File: rtl/apb_event_sink.sv
// APB completer that decodes event-notification writes, counts them per event and logs {id, data} in a FIFO.
// Optional error response on unmapped addresses: define APB_EVENT_SINK_PSLVERR_EN.
module apb_event_sink #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apb_psel_i,
    input  logic             apb_penable_i,
    input  logic [31:0]      apb_paddr_i,
    input  logic             apb_pwrite_i,
    input  logic [31:0]      apb_pwdata_i,
    output logic             apb_pready_o,
    output logic             log_valid_o,
    output logic [1:0]       log_id_o,
    output logic [31:0]      log_data_o,
    input  logic             log_ready_i,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o,
    output logic [CNT_W-1:0] cnt_c_o,
    output logic             overflow_o
`ifdef APB_EVENT_SINK_PSLVERR_EN
    ,
    output logic             apb_pslverr_o
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = 3;

    localparam logic [31:0] ADDR_A = 32'hABBA_0000;
    localparam logic [31:0] ADDR_B = 32'hBAFF_0000;
    localparam logic [31:0] ADDR_C = 32'hCAFE_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } log_entry_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    log_entry_t        mem_q [FIFO_DEPTH];
    log_entry_t        mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]  cnt_c_q, cnt_c_d;
    logic              overflow_q, overflow_d;

    logic [1:0]        ev_id_c;
    logic              pready_c;
    logic              commit_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              empty_c;

    // Exact-match address decode; 0 means unmapped.
    always_comb begin
        ev_id_c = 2'd0;
        if (apb_paddr_i == ADDR_A) begin
            ev_id_c = 2'd1;
        end else if (apb_paddr_i == ADDR_B) begin
            ev_id_c = 2'd2;
        end else if (apb_paddr_i == ADDR_C) begin
            ev_id_c = 2'd3;
        end
    end

    assign pready_c = (state_q == ACCESS) && apb_penable_i && (wait_q == WW'(WAIT_STATES));
    assign commit_c = apb_psel_i && pready_c;
    assign empty_c  = (wr_ptr_q == rd_ptr_q);
    assign full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c    = log_ready_i && !empty_c;
    assign push_c   = commit_c && apb_pwrite_i && (ev_id_c != 2'd0);

    // Next-state: transfer FSM, FIFO, counters and sticky overflow.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        cnt_c_d    = cnt_c_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (!apb_psel_i || pready_c) begin
                    state_d = IDLE;
                end else if (wait_q < WW'(WAIT_STATES)) begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        if (push_c) begin
            if (!full_c || pop_c) begin
                mem_d[wr_ptr_q[AW-1:0]] = '{id: ev_id_c, data: apb_pwdata_i};
                wr_ptr_d                = wr_ptr_q + PW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (push_c) begin
            case (ev_id_c)
                2'd1: if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
                2'd2: if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
                2'd3: if (cnt_c_q != '1) cnt_c_d = cnt_c_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            cnt_c_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            cnt_c_q    <= cnt_c_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign apb_pready_o = pready_c;
    assign log_valid_o  = !empty_c;
    assign log_id_o     = empty_c ? 2'd0  : mem_q[rd_ptr_q[AW-1:0]].id;
    assign log_data_o   = empty_c ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]].data;
    assign cnt_a_o      = cnt_a_q;
    assign cnt_b_o      = cnt_b_q;
    assign cnt_c_o      = cnt_c_q;
    assign overflow_o   = overflow_q;

`ifdef APB_EVENT_SINK_PSLVERR_EN
    assign apb_pslverr_o = pready_c && (ev_id_c == 2'd0);
`endif

endmodule

// File: tb/tb_apb_event_sink.sv
// Directed bench for apb_event_sink: one instance with WAIT_STATES=1/CNT_W=4, one with WAIT_STATES=3.
module tb_apb_event_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite, sel3;
    logic        log_ready1, log_ready3;
    logic [31:0] paddr, pwdata;

    logic        pready1, valid1, ovf1, err1;
    logic [1:0]  id1;
    logic [31:0] data1;
    logic [3:0]  ca1, cb1, cc1;

    logic        pready3, valid3, ovf3, err3;
    logic [1:0]  id3;
    logic [31:0] data3;
    logic [15:0] ca3, cb3, cc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_event_sink #(.WAIT_STATES(1), .FIFO_DEPTH(4), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel && !sel3), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata), .apb_pready_o(pready1),
        .log_valid_o(valid1), .log_id_o(id1), .log_data_o(data1), .log_ready_i(log_ready1),
        .cnt_a_o(ca1), .cnt_b_o(cb1), .cnt_c_o(cc1), .overflow_o(ovf1)
`ifdef APB_EVENT_SINK_PSLVERR_EN
        , .apb_pslverr_o(err1)
`endif
    );

    apb_event_sink #(.WAIT_STATES(3), .FIFO_DEPTH(4), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel && sel3), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata), .apb_pready_o(pready3),
        .log_valid_o(valid3), .log_id_o(id3), .log_data_o(data3), .log_ready_i(log_ready3),
        .cnt_a_o(ca3), .cnt_b_o(cb3), .cnt_c_o(cc3), .overflow_o(ovf3)
`ifdef APB_EVENT_SINK_PSLVERR_EN
        , .apb_pslverr_o(err3)
`endif
    );

`ifndef APB_EVENT_SINK_PSLVERR_EN
    assign err1 = 1'b0;
    assign err3 = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  exp_a, exp_b, exp_c;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer on the selected instance; optional pop on the commit edge.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic pop, output logic err);
        int   waits;
        logic done;
        logic rdy;
        err = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            rdy = sel3 ? pready3 : pready1;
            if (rdy) begin
                err = sel3 ? err3 : err1;
                if (sel3) log_ready3 = pop; else log_ready1 = pop;
                @(posedge clk); #1;
                psel = 1'b0; penable = 1'b0; log_ready1 = 1'b0; log_ready3 = 1'b0;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 30) begin
                    psel = 1'b0; penable = 1'b0;
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        chk("ready_latency", 32'(waits), sel3 ? 32'd4 : 32'd2);
    endtask

    task automatic drain1(input logic [1:0] eid, input logic [31:0] edata);
        chk("drain_valid", 32'(valid1), 32'd1);
        chk("drain_id", 32'(id1), 32'(eid));
        chk("drain_data", data1, edata);
        @(posedge clk); #1;
        log_ready1 = 1'b1;
        @(posedge clk); #1;
        log_ready1 = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic e;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel3 = 1'b0;
        paddr = '0; pwdata = '0; log_ready1 = 1'b0; log_ready3 = 1'b0;

        vecs[0] = '{32'h1234_0000, 1'b1, 32'd7, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0, 1'b1};
        vecs[1] = '{32'hABBA_0000, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 32'd0, 1'b0};
        vecs[2] = '{32'hABBA_0000, 1'b1, 32'd5, 4'd1, 4'd0, 4'd0, 1'b1, 2'd1, 32'd5, 1'b0};
        vecs[3] = '{32'hBAFF_0000, 1'b1, 32'd9, 4'd1, 4'd1, 4'd0, 1'b1, 2'd1, 32'd5, 1'b0};
        vecs[4] = '{32'hCAFE_0000, 1'b1, 32'd2, 4'd1, 4'd1, 4'd1, 1'b1, 2'd1, 32'd5, 1'b0};
        vecs[5] = '{32'hCAFE_0000, 1'b0, 32'd0, 4'd1, 4'd1, 4'd1, 1'b1, 2'd1, 32'd5, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", 32'(pready1), 32'd0);
        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_id", 32'(id1), 32'd0);
        chk("rst_data", data1, 32'd0);
        chk("rst_cnt", {20'd0, ca1, cb1, cc1}, 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        reset = 1'b0;

        // Table: unmapped write, read, then one write per event, no pops.
        for (int i = 0; i < 6; i++) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].data, 1'b0, e);
            chk("vec_cnt_a", 32'(ca1), 32'(vecs[i].exp_a));
            chk("vec_cnt_b", 32'(cb1), 32'(vecs[i].exp_b));
            chk("vec_cnt_c", 32'(cc1), 32'(vecs[i].exp_c));
            chk("vec_valid", 32'(valid1), 32'(vecs[i].exp_valid));
            chk("vec_id", 32'(id1), 32'(vecs[i].exp_id));
            chk("vec_data", data1, vecs[i].exp_data);
`ifdef APB_EVENT_SINK_PSLVERR_EN
            chk("vec_pslverr", 32'(e), 32'(vecs[i].exp_err));
`endif
        end

        drain1(2'd1, 32'd5);
        drain1(2'd2, 32'd9);
        drain1(2'd3, 32'd2);
        chk("empty_valid", 32'(valid1), 32'd0);
        chk("empty_id", 32'(id1), 32'd0);
        chk("empty_data", data1, 32'd0);

        // Overflow: five C writes into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) begin
            xfer(32'hCAFE_0000, 1'b1, 32'(10 + i), 1'b0, e);
            chk("ovf_flag", 32'(ovf1), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("ovf_cnt_c", 32'(cc1), 32'd6);
        for (int i = 0; i < 4; i++) drain1(2'd3, 32'(10 + i));
        chk("ovf_drained", 32'(valid1), 32'd0);
        chk("ovf_sticky", 32'(ovf1), 32'd1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        chk("post_rst_ovf", 32'(ovf1), 32'd0);
        for (int i = 0; i < 4; i++) xfer(32'hCAFE_0000, 1'b1, 32'(20 + i), 1'b0, e);
        xfer(32'hBAFF_0000, 1'b1, 32'd99, 1'b1, e);
        chk("full_pp_ovf", 32'(ovf1), 32'd0);
        chk("full_pp_cnt_b", 32'(cb1), 32'd1);
        drain1(2'd3, 32'd21);
        drain1(2'd3, 32'd22);
        drain1(2'd3, 32'd23);
        drain1(2'd2, 32'd99);
        chk("full_pp_empty", 32'(valid1), 32'd0);

        // Empty FIFO push with pop, then counter saturation.
        do_reset();
        xfer(32'hABBA_0000, 1'b1, 32'd100, 1'b1, e);
        chk("empty_pp_valid", 32'(valid1), 32'd1);
        chk("empty_pp_id", 32'(id1), 32'd1);
        chk("empty_pp_data", data1, 32'd100);
        for (int i = 1; i < 16; i++) begin
            xfer(32'hABBA_0000, 1'b1, 32'(100 + i), 1'b0, e);
            if (i == 14) chk("sat_cnt_15", 32'(ca1), 32'd15);
        end
        chk("sat_cnt_a", 32'(ca1), 32'd15);
        chk("sat_ovf", 32'(ovf1), 32'd1);

        // Abort and mid-transfer reset on the WAIT_STATES=3 instance.
        sel3 = 1'b1;
        xfer(32'hABBA_0000, 1'b1, 32'd1, 1'b0, e);
        chk("ws3_cnt_a", 32'(ca3), 32'd1);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'hBAFF_0000; pwrite = 1'b1; pwdata = 32'd2;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_cnt_b", 32'(cb3), 32'd0);
        chk("abort_cnt_a", 32'(ca3), 32'd1);
        chk("abort_head_id", 32'(id3), 32'd1);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'hCAFE_0000; pwrite = 1'b1; pwdata = 32'd3;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready3), 32'd0);
        chk("midrst_cnt_a", 32'(ca3), 32'd0);
        chk("midrst_valid", 32'(valid3), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_cnt_c", 32'(cc3), 32'd0);

        xfer(32'hCAFE_0000, 1'b1, 32'h33, 1'b0, e);
        chk("after_rst_cnt_c", 32'(cc3), 32'd1);
        chk("after_rst_valid", 32'(valid3), 32'd1);
        chk("after_rst_id", 32'(id3), 32'd3);
        chk("after_rst_data", data3, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
